light_decoder: RTL and testbench



---
 rtl/light_pkg.sv | 42 ++++
 rtl/code_debounce.sv | 50 +++++
 rtl/light_decoder.sv | 71 +++++++
 tb/tb_light_decoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared light-code constants, turn chase states and lamp patterns
// for the rear-lamp decoder.
package light_pkg;

  localparam logic [1:0] CODE_OFF   = 2'b00;
  localparam logic [1:0] CODE_BRAKE = 2'b01;
  localparam logic [1:0] CODE_TURN  = 2'b10;
  localparam logic [1:0] CODE_BOTH  = 2'b11;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_S1  = 3'b001;
  localparam logic [2:0] LAMP_S2  = 3'b011;
  localparam logic [2:0] LAMP_S3  = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    BLANK = 3'd4
  } turn_state_e;

  function automatic turn_state_e next_phase(input turn_state_e st);
    case (st)
      S1:      next_phase = S2;
      S2:      next_phase = S3;
      S3:      next_phase = BLANK;
      BLANK:   next_phase = S1;
      default: next_phase = IDLE;
    endcase
  endfunction

  function automatic logic [2:0] lamp_of(input turn_state_e st);
    case (st)
      S1:      lamp_of = LAMP_S1;
      S2:      lamp_of = LAMP_S2;
      S3:      lamp_of = LAMP_S3;
      default: lamp_of = LAMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/code_debounce.sv
// Accepts a new light code only after it has been seen on STABLE_CYC
// consecutive edges; shorter glitches are discarded.
module code_debounce
  import light_pkg::*;
#(
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] trans,
  output logic [1:0] cur_code
);

  localparam int SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC + 1) : 1;
  localparam logic [SW-1:0] LAST_STAB = SW'(STABLE_CYC - 1);

  logic [1:0]    cur_code_r;
  logic [1:0]    candidate_r;
  logic [SW-1:0] stab_cnt_r;

  // Candidate tracking, persistence count and acceptance of the code
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_code_r  <= CODE_OFF;
      candidate_r <= CODE_OFF;
      stab_cnt_r  <= {SW{1'b0}};
    end else if (trans == cur_code_r) begin
      stab_cnt_r <= {SW{1'b0}};
    end else if ((trans == candidate_r) && (stab_cnt_r != {SW{1'b0}})) begin
      if (stab_cnt_r == LAST_STAB) begin
        cur_code_r <= trans;
        stab_cnt_r <= {SW{1'b0}};
      end else begin
        stab_cnt_r <= stab_cnt_r + SW'(1);
      end
    end else begin
      // A fresh value (including a third one mid-count) restarts at 1
      candidate_r <= trans;
      if (STABLE_CYC == 1) begin
        cur_code_r <= trans;
        stab_cnt_r <= {SW{1'b0}};
      end else begin
        stab_cnt_r <= SW'(1);
      end
    end
  end

  assign cur_code = cur_code_r;

endmodule

// File: rtl/light_decoder.sv
// Rear-lamp decoder: debounced light code drives a steady brake lamp and
// a prescaled 3-lamp sequential turn chase.
module light_decoder
  import light_pkg::*;
#(
  parameter int TICK_DIV   = 12500000,
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] trans,
  output logic [1:0] cur_code,
  output logic       brake_lamp,
  output logic [2:0] turn_lamp
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(TICK_DIV - 1);

  logic [1:0]    cur_code_s;
  logic [TW-1:0] tick_cnt_r;
  turn_state_e   state_r;
  logic [2:0]    turn_lamp_r;

  code_debounce #(.STABLE_CYC(STABLE_CYC)) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .trans    (trans),
    .cur_code (cur_code_s)
  );

  // Turn chase FSM with phase prescaler; lamp pattern registered with state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      tick_cnt_r  <= {TW{1'b0}};
      turn_lamp_r <= LAMP_OFF;
    end else if (!cur_code_s[1]) begin
      state_r     <= IDLE;
      tick_cnt_r  <= {TW{1'b0}};
      turn_lamp_r <= LAMP_OFF;
    end else begin
      case (state_r)
        IDLE: begin
          state_r     <= S1;
          tick_cnt_r  <= {TW{1'b0}};
          turn_lamp_r <= LAMP_S1;
        end
        S1, S2, S3, BLANK: begin
          if (tick_cnt_r == LAST_TICK) begin
            tick_cnt_r  <= {TW{1'b0}};
            state_r     <= next_phase(state_r);
            turn_lamp_r <= lamp_of(next_phase(state_r));
          end else begin
            tick_cnt_r  <= tick_cnt_r + TW'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          tick_cnt_r  <= {TW{1'b0}};
          turn_lamp_r <= LAMP_OFF;
        end
      endcase
    end
  end

  assign cur_code   = cur_code_s;
  assign brake_lamp = cur_code_s[0];
  assign turn_lamp  = turn_lamp_r;

endmodule

// File: tb/tb_light_decoder.sv
// Directed bench for light_decoder with TICK_DIV=4, STABLE_CYC=2;
// expected values are hand-derived edge by edge.
module tb_light_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] trans;
  logic [1:0] cur_code;
  logic       brake_lamp;
  logic [2:0] turn_lamp;

  int checks   = 0;
  int failures = 0;

  light_decoder #(.TICK_DIV(4), .STABLE_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .trans      (trans),
    .cur_code   (cur_code),
    .brake_lamp (brake_lamp),
    .turn_lamp  (turn_lamp)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] code, input logic [2:0] lamp);
    chk({tag, "_code"},  {6'd0, cur_code},  {6'd0, code});
    chk({tag, "_brake"}, {7'd0, brake_lamp}, {7'd0, code[0]});
    chk({tag, "_turn"},  {5'd0, turn_lamp},  {5'd0, lamp});
  endtask

  initial begin
    rst   = 1'b1;
    trans = 2'b00;
    step(2);
    chk_all("reset", 2'b00, 3'b000);

    // 1: brake accepted after edge 1
    rst   = 1'b0;
    trans = 2'b01;
    step(1);
    chk_all("t1_e0", 2'b00, 3'b000);
    step(1);
    chk_all("t1_e1", 2'b01, 3'b000);

    // 2: turn chase timing
    trans = 2'b10;
    step(1);
    chk_all("t2_e0", 2'b01, 3'b000);
    step(1);
    chk_all("t2_e1", 2'b10, 3'b000);
    step(1);
    chk_all("t2_e2", 2'b10, 3'b001);
    step(3);
    chk_all("t2_e5", 2'b10, 3'b001);
    step(1);
    chk_all("t2_e6", 2'b10, 3'b011);
    step(4);
    chk_all("t2_e10", 2'b10, 3'b111);
    step(4);
    chk_all("t2_e14", 2'b10, 3'b000);
    step(4);
    chk_all("t2_e18", 2'b10, 3'b001);

    // 4: 10->11 mid-chase leaves chase timing intact
    step(4);
    chk_all("t4_s2", 2'b10, 3'b011);
    trans = 2'b11;
    step(1);
    chk_all("t4_e1", 2'b10, 3'b011);
    step(1);
    chk_all("t4_e2", 2'b11, 3'b011);
    step(1);
    chk_all("t4_e3", 2'b11, 3'b011);
    step(1);
    chk_all("t4_e4", 2'b11, 3'b111);

    // 5: turn drops in S3, then restarts
    trans = 2'b00;
    step(1);
    chk_all("t5_e1", 2'b11, 3'b111);
    step(1);
    chk_all("t5_e2", 2'b00, 3'b111);
    step(1);
    chk_all("t5_e3", 2'b00, 3'b000);
    trans = 2'b10;
    step(2);
    chk_all("t5_f2", 2'b10, 3'b000);
    step(1);
    chk_all("t5_f3", 2'b10, 3'b001);
    step(3);
    chk_all("t5_f6", 2'b10, 3'b001);
    step(1);
    chk_all("t5_f7", 2'b10, 3'b011);

    // 6: reset while in S3 with code 11
    trans = 2'b11;
    step(2);
    chk_all("t6_g2", 2'b11, 3'b011);
    step(2);
    chk_all("t6_s3", 2'b11, 3'b111);
    rst = 1'b1;
    step(1);
    chk_all("t6_rst", 2'b00, 3'b000);
    rst = 1'b0;
    step(1);
    chk_all("t6_h1", 2'b00, 3'b000);
    step(1);
    chk_all("t6_h2", 2'b11, 3'b000);
    step(1);
    chk_all("t6_h3", 2'b11, 3'b001);

    // 3: one-cycle glitch rejected, third value restarts the count
    trans = 2'b00;
    step(3);
    chk_all("t3_off", 2'b00, 3'b000);
    trans = 2'b01;
    step(1);
    chk_all("t3_glitch", 2'b00, 3'b000);
    trans = 2'b00;
    step(1);
    chk_all("t3_after", 2'b00, 3'b000);
    trans = 2'b01;
    step(1);
    chk_all("t3_c", 2'b00, 3'b000);
    trans = 2'b11;
    step(1);
    chk_all("t3_d", 2'b00, 3'b000);
    step(1);
    chk_all("t3_e", 2'b11, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
